// File: rtl/axi_lite_chk_pkg.sv
// Shared response codes, FSM states and LFSR taps for the AXI4-Lite write/readback checker.
package axi_lite_chk_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_CHECK,
    ST_FINISH
  } state_e;

  // Right-shifting Galois masks: the bit shifted out of bit 0 is folded back through these taps.
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/axi_lite_chk_patgen.sv
// Pattern word generator: load latches seed/mode (word = seed), advance steps to the next word.
// Word is registered; one advance per cycle, no backpressure.
module axi_lite_chk_patgen
  import axi_lite_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  load,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] word
);

  localparam logic [DATA_WIDTH-1:0] TAPS = (DATA_WIDTH == 64) ? DATA_WIDTH'(LFSR_TAPS_64)
                                                               : DATA_WIDTH'(LFSR_TAPS_32);

  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  always_comb begin
    mode_d = mode_q;
    word_d = word_q;
    if (load) begin
      mode_d = mode;
      // An all-zero LFSR state would lock up, so it is replaced by all-ones.
      word_d = (mode && (seed == '0)) ? '1 : seed;
    end else if (advance) begin
      if (mode_q) word_d = (word_q >> 1) ^ (word_q[0] ? TAPS : '0);
      else        word_d = word_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      word_q <= '0;
    end else begin
      mode_q <= mode_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/axi_lite_wr_rd_checker.sv
// AXI4-Lite BIST master: per word writes a pattern, reads it back, checks BRESP/RRESP and data.
// Zero-wait slave costs 6 cycles per word; each wait state aborts the run after TIMEOUT_CYCLES.
module axi_lite_wr_rd_checker
  import axi_lite_chk_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    NUM_WORDS      = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    ADDR_STRIDE    = 4,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic                    mode,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [DATA_WIDTH-1:0]   first_err_exp,
  output logic [DATA_WIDTH-1:0]   first_err_act,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                state_q, state_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0]           idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] fe_addr_q, fe_addr_d;
  logic [DATA_WIDTH-1:0] fe_exp_q, fe_exp_d, fe_act_q, fe_act_d;
  logic                  pass_q, pass_d, timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0] pat_word, err_exp, err_act;
  logic                  tmo, last, err_vld;

  assign tmo  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign last = (idx_q == 16'(NUM_WORDS - 1));

  axi_lite_chk_patgen #(.DATA_WIDTH(DATA_WIDTH)) u_patgen (
    .clk     (ACLK),
    .rst     (ARESET),
    .mode    (mode),
    .seed    (seed),
    .load    ((state_q == ST_IDLE) && start),
    .advance ((state_q == ST_CHECK) && !last),
    .word    (pat_word)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A handshake that lands on the timeout cycle still wins over the abort.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_WR;
      ST_WR:      if (aw_done_q && w_done_q) state_d = ST_WR_RESP; else if (tmo) state_d = ST_FINISH;
      ST_WR_RESP: if (m_axi_bvalid)  state_d = ST_RD_ADDR;  else if (tmo) state_d = ST_FINISH;
      ST_RD_ADDR: if (m_axi_arready) state_d = ST_RD_DATA;  else if (tmo) state_d = ST_FINISH;
      ST_RD_DATA: if (m_axi_rvalid)  state_d = ST_CHECK;    else if (tmo) state_d = ST_FINISH;
      ST_CHECK:   state_d = last ? ST_FINISH : ST_WR;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = (state_q == ST_WR) && !aw_done_q;
    m_axi_wvalid  = (state_q == ST_WR) && !w_done_q;
    m_axi_bready  = (state_q == ST_WR_RESP);
    m_axi_arvalid = (state_q == ST_RD_ADDR);
    m_axi_rready  = (state_q == ST_RD_DATA);
    done          = (state_q == ST_FINISH);
    busy          = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  end

  always_comb begin
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    err_count_d = err_count_q;
    fe_addr_d   = fe_addr_q;
    fe_exp_d    = fe_exp_q;
    fe_act_d    = fe_act_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_vld     = 1'b0;
    err_exp     = '0;
    err_act     = '0;
    cnt_d       = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + CW'(1);

    unique case (state_q)
      ST_IDLE: if (start) begin
        aw_done_d   = 1'b0;
        w_done_d    = 1'b0;
        idx_d       = '0;
        addr_d      = BASE_ADDR;
        err_count_d = '0;
        fe_addr_d   = '0;
        fe_exp_d    = '0;
        fe_act_d    = '0;
        pass_d      = 1'b0;
        timeout_d   = 1'b0;
      end
      ST_WR: begin
        if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
        if (m_axi_wvalid  && m_axi_wready)  w_done_d  = 1'b1;
      end
      ST_WR_RESP: if (m_axi_bvalid && (m_axi_bresp != RESP_OKAY)) begin
        err_vld = 1'b1;
        err_exp = pat_word;
      end
      ST_RD_DATA: if (m_axi_rvalid) begin
        rdata_d = m_axi_rdata;
        rresp_d = m_axi_rresp;
      end
      ST_CHECK: begin
        if ((rresp_q != RESP_OKAY) || (rdata_q != pat_word)) begin
          err_vld = 1'b1;
          err_exp = pat_word;
          err_act = rdata_q;
        end
        if (!last) begin
          idx_d     = idx_q + 16'd1;
          addr_d    = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: ;
    endcase

    if (err_vld) begin
      if (err_count_q == '0) begin
        fe_addr_d = addr_q;
        fe_exp_d  = err_exp;
        fe_act_d  = err_act;
      end
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    end

    // Only a wait state can reach FINISH without completing the last CHECK.
    if ((state_d == ST_FINISH) && (state_q != ST_CHECK) && (state_q != ST_FINISH)) timeout_d = 1'b1;
    if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) pass_d = (err_count_d == '0) && !timeout_d;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      err_count_q <= '0;
      fe_addr_q   <= '0;
      fe_exp_q    <= '0;
      fe_act_q    <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      err_count_q <= err_count_d;
      fe_addr_q   <= fe_addr_d;
      fe_exp_q    <= fe_exp_d;
      fe_act_q    <= fe_act_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  assign m_axi_awaddr   = addr_q;
  assign m_axi_araddr   = addr_q;
  assign m_axi_wdata    = pat_word;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_wstrb    = '1;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_count_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_act  = fe_act_q;

endmodule

// File: tb/tb_axi_lite_wr_rd_checker.sv
// Bench for axi_lite_wr_rd_checker: memory slave with fault injection plus a transaction-level model.
module tb_axi_lite_wr_rd_checker;

  localparam int NW = 4;

  logic        ACLK = 1'b0;
  logic        ARESET, start, mode;
  logic [31:0] seed;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr, first_err_exp, first_err_act;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  axi_lite_wr_rd_checker #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WORDS(NW), .BASE_ADDR(32'h0),
    .ADDR_STRIDE(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_exp(first_err_exp), .first_err_act(first_err_act),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference pattern straight from the rule: seed+index, or the LFSR stepped index times.
  function automatic logic [31:0] gen_word(input logic m, input logic [31:0] s, input int i);
    logic [31:0] v;
    if (!m) return s + 32'(i);
    v = (s == 32'h0) ? 32'hFFFF_FFFF : s;
    for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    return v;
  endfunction

  // Slave fault configuration, set by the main sequence before each run.
  logic        cfg_rand = 1'b0, cfg_flip_en = 1'b0, cfg_no_ar = 1'b0;
  logic [31:0] cfg_flip_addr = 32'h0;
  int          cfg_berr_idx = -1, cfg_rerr_idx = -1;
  logic [31:0] mem [logic [31:0]];

  // Slave: updates at the falling edge, handshakes are those seen at the following rising edge.
  initial begin : slave
    logic aw_have, w_have, b_wait, b_act, r_wait, r_act, h_aw, h_w, h_b, h_ar, h_r;
    logic [31:0] aw_a, w_d, ar_a, c_aw, c_w, c_ar;
    logic [1:0] b_rsp;
    int b_cnt, r_cnt, aw_st, w_st, ar_st;
    {aw_have, w_have, b_wait, b_act, r_wait, r_act, h_aw, h_w, h_b, h_ar, h_r} = '0;
    {aw_a, w_d, ar_a, c_aw, c_w, c_ar} = '0;
    b_rsp = 2'b00; b_cnt = 0; r_cnt = 0; aw_st = 0; w_st = 0; ar_st = 0;
    {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
    m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = 32'h0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        {aw_have, w_have, b_wait, b_act, r_wait, r_act, h_aw, h_w, h_b, h_ar, h_r} = '0;
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
        aw_st = 0; w_st = 0; ar_st = 0;
      end else begin
        if (h_aw) begin aw_have = 1'b1; aw_a = c_aw; end
        if (h_w)  begin w_have = 1'b1;  w_d = c_w;   end
        if (h_b)  b_act = 1'b0;
        if (h_r)  r_act = 1'b0;
        if (h_ar) begin ar_a = c_ar; r_wait = 1'b1; r_cnt = cfg_rand ? int'($urandom_range(0, 7)) : 0; end
        if (aw_have && w_have) begin
          mem[aw_a] = w_d;
          b_rsp  = (int'(aw_a >> 2) == cfg_berr_idx) ? 2'b10 : 2'b00;
          b_wait = 1'b1;
          b_cnt  = cfg_rand ? int'($urandom_range(0, 7)) : 0;
          aw_have = 1'b0; w_have = 1'b0;
        end
        if (b_wait) begin
          if (b_cnt == 0) begin b_wait = 1'b0; b_act = 1'b1; end else b_cnt--;
        end
        if (r_wait) begin
          if (r_cnt == 0) begin
            r_wait = 1'b0; r_act = 1'b1;
            m_axi_rdata = (mem.exists(ar_a) ? mem[ar_a] : 32'h0) ^ {31'h0, cfg_flip_en && (ar_a == cfg_flip_addr)};
            m_axi_rresp = (int'(ar_a >> 2) == cfg_rerr_idx) ? 2'b11 : 2'b00;
          end else r_cnt--;
        end
        aw_st = (m_axi_awvalid && !m_axi_awready) ? aw_st + 1 : 0;
        w_st  = (m_axi_wvalid  && !m_axi_wready)  ? w_st + 1  : 0;
        ar_st = (m_axi_arvalid && !m_axi_arready) ? ar_st + 1 : 0;
        m_axi_awready = !aw_have && (!cfg_rand || $urandom_range(0, 3) != 0 || aw_st >= 4);
        m_axi_wready  = !w_have  && (!cfg_rand || $urandom_range(0, 3) != 0 || w_st >= 4);
        m_axi_arready = !cfg_no_ar && !r_wait && !r_act && (!cfg_rand || $urandom_range(0, 3) != 0 || ar_st >= 4);
        m_axi_bvalid  = b_act;
        m_axi_bresp   = b_rsp;
        m_axi_rvalid  = r_act;
        h_aw = m_axi_awvalid && m_axi_awready; c_aw = m_axi_awaddr;
        h_w  = m_axi_wvalid  && m_axi_wready;  c_w  = m_axi_wdata;
        h_b  = m_axi_bvalid  && m_axi_bready;
        h_ar = m_axi_arvalid && m_axi_arready; c_ar = m_axi_araddr;
        h_r  = m_axi_rvalid  && m_axi_rready;
      end
    end
  end

  // Model state for the run in flight.
  logic        run_active = 1'b0, pending = 1'b0, prev_done = 1'b0;
  logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, cur_mode = 1'b0;
  logic [31:0] cur_seed = 32'h0, m_w, m_a, m_rd;
  int          aw_n, w_n, ar_n, cyc = 0, ar_t0 = -1, done_cnt = 0;
  int          exp_errs, exp_nwr, exp_nrd;
  logic        exp_timeout, exp_pass;
  logic [31:0] exp_fa, exp_fe, exp_fx;

  task automatic note_err(input logic [31:0] a, input logic [31:0] e, input logic [31:0] x);
    if (exp_errs == 0) begin exp_fa = a; exp_fe = e; exp_fx = x; end
    exp_errs++;
  endtask

  initial begin : compare
    logic hs_aw, hs_w, hs_ar;
    forever begin
      @(negedge ACLK); #1;
      cyc++;
      hs_aw = m_axi_awvalid && m_axi_awready;
      hs_w  = m_axi_wvalid  && m_axi_wready;
      hs_ar = m_axi_arvalid && m_axi_arready;
      if (ARESET) begin
        run_active = 1'b0; pending = 1'b0; prev_done = 1'b0;
        p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
      end else begin
        if (pending) begin run_active = 1'b1; pending = 1'b0; end
        if (prev_done) chk("done_one_cycle", done, 1'b0);
        chk("busy", busy, run_active && !done);
        if (run_active) begin
          chk("prot_strb", {m_axi_awprot, m_axi_arprot, m_axi_wstrb}, {3'b000, 3'b000, 4'hF});
          if (p_aw && !done) chk("awvalid_hold", m_axi_awvalid, 1'b1);
          if (p_w  && !done) chk("wvalid_hold",  m_axi_wvalid,  1'b1);
          if (p_ar && !done) chk("arvalid_hold", m_axi_arvalid, 1'b1);
          if (hs_aw) begin chk("awaddr", m_axi_awaddr, 32'(aw_n * 4)); aw_n++; end
          if (hs_w)  begin chk("wdata", m_axi_wdata, gen_word(cur_mode, cur_seed, w_n)); w_n++; end
          if (hs_ar) begin chk("araddr", m_axi_araddr, 32'(ar_n * 4)); ar_n++; end
          if (m_axi_arvalid && ar_t0 < 0) ar_t0 = cyc;
          if (done) begin
            done_cnt++;
            chk("pass", pass, exp_pass);
            chk("timeout", timeout, exp_timeout);
            chk("err_count", err_count, 16'(exp_errs));
            chk("first_err_addr", first_err_addr, exp_fa);
            chk("first_err_exp", first_err_exp, exp_fe);
            chk("first_err_act", first_err_act, exp_fx);
            chk("writes_done", 32'(w_n), 32'(exp_nwr));
            chk("reads_done", 32'(ar_n), 32'(exp_nrd));
            chk("fin_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
            if (exp_timeout) chk("tmo_latency", (ar_t0 >= 0) && (cyc - ar_t0 <= 17), 1'b1);
            run_active = 1'b0;
          end
        end
        p_aw = m_axi_awvalid && !hs_aw;
        p_w  = m_axi_wvalid  && !hs_w;
        p_ar = m_axi_arvalid && !hs_ar;
        prev_done = done;
        if (start && !run_active && !busy && !pending) begin
          pending = 1'b1;
          cur_mode = mode; cur_seed = seed;
          aw_n = 0; w_n = 0; ar_n = 0; ar_t0 = -1;
          exp_errs = 0; exp_fa = 32'h0; exp_fe = 32'h0; exp_fx = 32'h0;
          exp_timeout = cfg_no_ar;
          exp_nwr = cfg_no_ar ? 1 : NW;
          exp_nrd = cfg_no_ar ? 0 : NW;
          if (!cfg_no_ar) for (int i = 0; i < NW; i++) begin
            m_w = gen_word(cur_mode, cur_seed, i);
            m_a = 32'(i * 4);
            if (i == cfg_berr_idx) note_err(m_a, m_w, 32'h0);
            m_rd = (cfg_flip_en && m_a == cfg_flip_addr) ? (m_w ^ 32'h1) : m_w;
            if (i == cfg_rerr_idx || m_rd != m_w) note_err(m_a, m_w, m_rd);
          end
          exp_pass = (exp_errs == 0) && !exp_timeout;
        end
      end
    end
  end

  task automatic pulse_start(input logic m, input logic [31:0] s);
    @(posedge ACLK); #1;
    mode = m; seed = s; start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0; mode = ~m; seed = ~s;
  endtask

  task automatic run(input logic m, input logic [31:0] s);
    int n;
    done_cnt = 0;
    pulse_start(m, s);
    n = 0;
    while (!done && n < 2000) begin @(posedge ACLK); #1; n++; end
    chk("run_reaches_done", done, 1'b1);
    repeat (3) @(posedge ACLK);
    #1;
    chk("done_count", 32'(done_cnt), 32'd1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_status"}, {busy, done, pass, timeout, err_count}, 20'h0);
    chk({tag, "_capture"}, {first_err_addr, first_err_exp, first_err_act}, 96'h0);
    chk({tag, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
  endtask

  initial begin : main
    ARESET = 1'b1; start = 1'b0; mode = 1'b0; seed = 32'h0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    chk_cleared("reset");
    chk("model_inc", gen_word(1'b0, 32'h0101_FFFF, 3), 32'h0102_0002);
    chk("model_lfsr_step", gen_word(1'b1, 32'h1, 1), 32'h8020_0003);
    chk("model_lfsr_zero", gen_word(1'b1, 32'h0, 0), 32'hFFFF_FFFF);

    run(1'b0, 32'h0101_FFFF);
    chk("t1_mem0", mem[32'h0], 32'h0101_FFFF);
    chk("t1_memC", mem[32'hC], 32'h0102_0002);
    chk("t1_pass", {pass, err_count}, {1'b1, 16'h0});

    cfg_rand = 1'b1;
    for (int r = 0; r < 16; r++) begin
      if (r == 0) run(1'b1, 32'hDEAD_0011);
      else        run(1'($urandom_range(0, 1)), $urandom);
      chk("t2_pass", pass, 1'b1);
    end
    cfg_rand = 1'b0;

    cfg_flip_en = 1'b1; cfg_flip_addr = 32'h8;
    run(1'b0, 32'hABCD_0001);
    chk("t3_result", {pass, err_count, first_err_addr}, {1'b0, 16'd1, 32'h8});
    chk("t3_data", {first_err_exp, first_err_act}, {32'hABCD_0003, 32'hABCD_0002});
    cfg_flip_en = 1'b0;

    cfg_berr_idx = 1; cfg_rerr_idx = 3;
    run(1'b0, 32'h1000_0000);
    chk("t4_result", {pass, err_count, first_err_addr}, {1'b0, 16'd2, 32'h4});
    chk("t4_data", {first_err_exp, first_err_act}, {32'h1000_0001, 32'h0});
    cfg_berr_idx = -1; cfg_rerr_idx = -1;

    cfg_no_ar = 1'b1;
    run(1'b0, 32'h0000_0005);
    chk("t5_result", {timeout, pass}, 2'b10);
    cfg_no_ar = 1'b0;

    pulse_start(1'b1, $urandom);
    repeat (9) @(posedge ACLK);
    #1 ARESET = 1'b1;
    @(posedge ACLK); #1 ARESET = 1'b0;
    chk_cleared("midrun_reset");
    run(1'b0, 32'h0000_0077);
    chk("t6_pass", {pass, timeout, err_count}, {2'b10, 16'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
